// File: rtl/pkt_desc_gen.sv
// ---------------------------------------------------------------------------
// pkt_desc_gen
//   Takes packet flits plus per-packet metadata from the flow director. It
//   writes each flit (optionally byte-swapped) into the packet buffer and
//   emits one descriptor per packet to the descriptor buffer. Packets longer
//   than MAX_FLITS are cut at MAX_FLITS: the last written flit carries eop,
//   and the remaining flits are consumed and discarded.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_*                        flit stream + metadata (valid/ready)
//   in_meta_ready               metadata pop, combinational, with the eop flit
//   out_pkt_*                   packet-buffer write port (registered)
//   out_desc_*                  descriptor write port (registered)
//   stat_*_cnt                  descriptors / truncations / orphan flits
// ---------------------------------------------------------------------------
module pkt_desc_gen #(
  parameter int DATA_WIDTH     = 512,
  parameter int EMPTY_WIDTH    = $clog2(DATA_WIDTH/8),
  parameter int APP_IDX_WIDTH  = 16,
  parameter int FLOW_IDX_WIDTH = 16,
  parameter int SIZE_WIDTH     = 16,
  parameter int MAX_PKT_BYTES  = 9216,
  parameter int BYTE_SWAP      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [EMPTY_WIDTH-1:0]    in_empty,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_meta_valid,
  input  logic [APP_IDX_WIDTH-1:0]  in_meta_dsc_queue_id,
  input  logic [FLOW_IDX_WIDTH-1:0] in_meta_pkt_queue_id,
  output logic                      in_meta_ready,
  output logic [DATA_WIDTH-1:0]     out_pkt_data,
  output logic                      out_pkt_sop,
  output logic                      out_pkt_eop,
  output logic                      out_pkt_wr_en,
  input  logic                      out_pkt_in_ready,
  output logic [APP_IDX_WIDTH-1:0]  out_desc_dsc_queue_id,
  output logic [FLOW_IDX_WIDTH-1:0] out_desc_pkt_queue_id,
  output logic [SIZE_WIDTH-1:0]     out_desc_size_bytes,
  output logic [SIZE_WIDTH-1:0]     out_desc_size_flits,
  output logic                      out_desc_truncated,
  output logic                      out_desc_wr_en,
  input  logic                      out_desc_in_ready,
  output logic [31:0]               stat_pkt_cnt,
  output logic [31:0]               stat_trunc_cnt,
  output logic [31:0]               stat_err_cnt
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int MAX_FLITS = (MAX_PKT_BYTES + BYTES - 1) / BYTES;
  localparam logic [SIZE_WIDTH-1:0] BYTES_SZ     = SIZE_WIDTH'(BYTES);
  localparam logic [SIZE_WIDTH-1:0] MAX_FLITS_SZ = SIZE_WIDTH'(MAX_FLITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } state_e;

  state_e                    state_q;
  logic [SIZE_WIDTH-1:0]     flits_q;

  logic [DATA_WIDTH-1:0]     pkt_data_q;
  logic                      pkt_sop_q, pkt_eop_q, pkt_wr_en_q;
  logic [APP_IDX_WIDTH-1:0]  dsc_qid_q;
  logic [FLOW_IDX_WIDTH-1:0] pkt_qid_q;
  logic [SIZE_WIDTH-1:0]     size_bytes_q, size_flits_q;
  logic                      truncated_q, desc_wr_en_q;
  logic [31:0]               pkt_cnt_q, trunc_cnt_q, err_cnt_q;

  logic                      accept;
  logic [SIZE_WIDTH-1:0]     flits_d;
  logic [SIZE_WIDTH-1:0]     bytes_full;
  logic [SIZE_WIDTH-1:0]     bytes_eop;
  logic                      hit_max;
  logic                      do_write, do_trunc, do_emit;
  logic                      orphan, stray_sop, drop_end;
  logic [DATA_WIDTH-1:0]     data_out;

  // -------------------------------------------------------------------------
  // Data path byte order
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < BYTES; i++) begin : g_byte
    if (BYTE_SWAP != 0) begin : g_swap
      assign data_out[i*8 +: 8] = in_data[(BYTES-1-i)*8 +: 8];
    end else begin : g_pass
      assign data_out[i*8 +: 8] = in_data[i*8 +: 8];
    end
  end

  // -------------------------------------------------------------------------
  // Handshake and per-flit decisions
  // -------------------------------------------------------------------------
  assign in_ready = out_pkt_in_ready & out_desc_in_ready & ~rst;
  assign accept   = in_valid & in_meta_valid & in_ready;

  // Flit count including the flit being accepted this cycle.
  assign flits_d    = (state_q == IDLE) ? SIZE_WIDTH'(1) : flits_q + SIZE_WIDTH'(1);
  assign hit_max    = (flits_d == MAX_FLITS_SZ);
  assign bytes_full = flits_d * BYTES_SZ;
  assign bytes_eop  = bytes_full - SIZE_WIDTH'(in_empty);

  assign do_write  = accept & (((state_q == IDLE) & in_sop) | (state_q == IN_PKT));
  // An eop on the MAX_FLITS flit is a normal end, so eop takes priority.
  assign do_trunc  = do_write & ~in_eop & hit_max;
  assign do_emit   = do_write & (in_eop | hit_max);
  assign orphan    = accept & (state_q == IDLE) & ~in_sop;
  assign stray_sop = accept & (state_q == IN_PKT) & in_sop;
  assign drop_end  = accept & (state_q == DROP) & in_eop;

  // Metadata is popped together with the flit that ends the packet on the
  // input side, whether it was written or dropped. A truncated packet keeps
  // its metadata until its real eop arrives in DROP.
  assign in_meta_ready = accept & in_eop & ((state_q != IDLE) | in_sop);

  // -------------------------------------------------------------------------
  // FSM and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking would chain them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flits_q      <= '0;
      pkt_data_q   <= '0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      pkt_wr_en_q  <= 1'b0;
      dsc_qid_q    <= '0;
      pkt_qid_q    <= '0;
      size_bytes_q <= '0;
      size_flits_q <= '0;
      truncated_q  <= 1'b0;
      desc_wr_en_q <= 1'b0;
      pkt_cnt_q    <= '0;
      trunc_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      // Strobes are single-cycle pulses.
      pkt_wr_en_q  <= 1'b0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      desc_wr_en_q <= 1'b0;
      truncated_q  <= 1'b0;

      if (do_write) begin
        pkt_data_q  <= data_out;
        pkt_wr_en_q <= 1'b1;
        // A stray sop inside a packet is written as a plain data flit.
        pkt_sop_q   <= (state_q == IDLE);
        pkt_eop_q   <= in_eop | do_trunc;
        flits_q     <= flits_d;
        if (do_trunc)    state_q <= DROP;
        else if (in_eop) state_q <= IDLE;
        else             state_q <= IN_PKT;
      end else if (drop_end) begin
        state_q <= IDLE;
      end

      if (do_emit) begin
        desc_wr_en_q <= 1'b1;
        dsc_qid_q    <= in_meta_dsc_queue_id;
        pkt_qid_q    <= in_meta_pkt_queue_id;
        size_flits_q <= flits_d;
        size_bytes_q <= do_trunc ? bytes_full : bytes_eop;
        truncated_q  <= do_trunc;
        pkt_cnt_q    <= pkt_cnt_q + 32'd1;
      end

      if (do_trunc) trunc_cnt_q <= trunc_cnt_q + 32'd1;
      if (orphan | stray_sop) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign out_pkt_data          = pkt_data_q;
  assign out_pkt_sop           = pkt_sop_q;
  assign out_pkt_eop           = pkt_eop_q;
  assign out_pkt_wr_en         = pkt_wr_en_q;
  assign out_desc_dsc_queue_id = dsc_qid_q;
  assign out_desc_pkt_queue_id = pkt_qid_q;
  assign out_desc_size_bytes   = size_bytes_q;
  assign out_desc_size_flits   = size_flits_q;
  assign out_desc_truncated    = truncated_q;
  assign out_desc_wr_en        = desc_wr_en_q;
  assign stat_pkt_cnt          = pkt_cnt_q;
  assign stat_trunc_cnt        = trunc_cnt_q;
  assign stat_err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_pkt_desc_gen.sv
// ---------------------------------------------------------------------------
// tb_pkt_desc_gen
//   Three instances share one stimulus stream:
//     a_ : default parameters (512-bit, BYTE_SWAP=1, MAX_PKT_BYTES=9216)
//     n_ : BYTE_SWAP=0
//     t_ : MAX_PKT_BYTES=256 (MAX_FLITS=4)
//   Expected values are hand-computed for 64-byte flits.
// ---------------------------------------------------------------------------
module tb_pkt_desc_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic         in_sop, in_eop, in_valid, in_meta_valid;
  logic [5:0]   in_empty;
  logic [15:0]  in_dq, in_pq;
  logic         pkt_rdy, desc_rdy;

  logic a_in_ready, a_mr, a_wr, a_sop, a_eop, a_dwr, a_trunc;
  logic [511:0] a_data;
  logic [15:0]  a_dq, a_pq, a_bytes, a_flits;
  logic [31:0]  a_pcnt, a_tcnt, a_ecnt;

  logic n_in_ready, n_mr, n_wr, n_sop, n_eop, n_dwr, n_trunc;
  logic [511:0] n_data;
  logic [15:0]  n_dq, n_pq, n_bytes, n_flits;
  logic [31:0]  n_pcnt, n_tcnt, n_ecnt;

  logic t_in_ready, t_mr, t_wr, t_sop, t_eop, t_dwr, t_trunc;
  logic [511:0] t_data;
  logic [15:0]  t_dq, t_pq, t_bytes, t_flits;
  logic [31:0]  t_pcnt, t_tcnt, t_ecnt;

  // Metadata-pop values captured just before the accepting edge.
  logic a_mr_s, t_mr_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_desc_gen dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_meta_valid(in_meta_valid), .in_meta_dsc_queue_id(in_dq),
    .in_meta_pkt_queue_id(in_pq), .in_meta_ready(a_mr),
    .out_pkt_data(a_data), .out_pkt_sop(a_sop), .out_pkt_eop(a_eop),
    .out_pkt_wr_en(a_wr), .out_pkt_in_ready(pkt_rdy),
    .out_desc_dsc_queue_id(a_dq), .out_desc_pkt_queue_id(a_pq),
    .out_desc_size_bytes(a_bytes), .out_desc_size_flits(a_flits),
    .out_desc_truncated(a_trunc), .out_desc_wr_en(a_dwr),
    .out_desc_in_ready(desc_rdy), .stat_pkt_cnt(a_pcnt),
    .stat_trunc_cnt(a_tcnt), .stat_err_cnt(a_ecnt)
  );

  pkt_desc_gen #(.BYTE_SWAP(0)) dut_n (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_meta_valid(in_meta_valid), .in_meta_dsc_queue_id(in_dq),
    .in_meta_pkt_queue_id(in_pq), .in_meta_ready(n_mr),
    .out_pkt_data(n_data), .out_pkt_sop(n_sop), .out_pkt_eop(n_eop),
    .out_pkt_wr_en(n_wr), .out_pkt_in_ready(pkt_rdy),
    .out_desc_dsc_queue_id(n_dq), .out_desc_pkt_queue_id(n_pq),
    .out_desc_size_bytes(n_bytes), .out_desc_size_flits(n_flits),
    .out_desc_truncated(n_trunc), .out_desc_wr_en(n_dwr),
    .out_desc_in_ready(desc_rdy), .stat_pkt_cnt(n_pcnt),
    .stat_trunc_cnt(n_tcnt), .stat_err_cnt(n_ecnt)
  );

  pkt_desc_gen #(.MAX_PKT_BYTES(256)) dut_t (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_meta_valid(in_meta_valid), .in_meta_dsc_queue_id(in_dq),
    .in_meta_pkt_queue_id(in_pq), .in_meta_ready(t_mr),
    .out_pkt_data(t_data), .out_pkt_sop(t_sop), .out_pkt_eop(t_eop),
    .out_pkt_wr_en(t_wr), .out_pkt_in_ready(pkt_rdy),
    .out_desc_dsc_queue_id(t_dq), .out_desc_pkt_queue_id(t_pq),
    .out_desc_size_bytes(t_bytes), .out_desc_size_flits(t_flits),
    .out_desc_truncated(t_trunc), .out_desc_wr_en(t_dwr),
    .out_desc_in_ready(desc_rdy), .stat_pkt_cnt(t_pcnt),
    .stat_trunc_cnt(t_tcnt), .stat_err_cnt(t_ecnt)
  );

  // Present one flit + metadata, capture the combinational pop, let it be
  // accepted at the next edge, then sample the registered outputs 1 ns later.
  task automatic send(input logic sop, input logic eop, input logic [5:0] empty,
                      input logic [511:0] data, input logic [15:0] dq,
                      input logic [15:0] pq);
    in_sop = sop; in_eop = eop; in_empty = empty; in_data = data;
    in_dq = dq; in_pq = pq; in_valid = 1'b1; in_meta_valid = 1'b1;
    #1;
    a_mr_s = a_mr;
    t_mr_s = t_mr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_meta_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_meta_valid = 1'b0; in_sop = 1'b0;
    in_eop = 1'b0; in_empty = '0; in_data = '0; in_dq = '0; in_pq = '0;
    pkt_rdy = 1'b1; desc_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready);
    end
    n_vec++;
    if ({a_wr, a_dwr, a_sop, a_eop, a_trunc} !== 5'b0 || a_pcnt !== 32'd0) begin
      n_err++; $display("FAIL reset_outputs got %b/%0d exp 00000/0",
                        {a_wr, a_dwr, a_sop, a_eop, a_trunc}, a_pcnt);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL release_in_ready got %b exp 1", a_in_ready);
    end
  endtask

  task automatic test_single();
    send(1'b1, 1'b1, 6'd4, {16{32'h1111_0001}}, 16'd3, 16'd7);
    n_vec++;
    if (a_mr_s !== 1'b1) begin
      n_err++; $display("FAIL single_meta_pop got %b exp 1", a_mr_s);
    end
    n_vec++;
    if ({a_wr, a_sop, a_eop, a_dwr, a_trunc} !== 5'b11110) begin
      n_err++; $display("FAIL single_strobes got %b exp 11110",
                        {a_wr, a_sop, a_eop, a_dwr, a_trunc});
    end
    n_vec++;
    if ({a_bytes, a_flits, a_dq, a_pq} !== {16'd60, 16'd1, 16'd3, 16'd7}) begin
      n_err++; $display("FAIL single_desc got %0d/%0d/%0d/%0d exp 60/1/3/7",
                        a_bytes, a_flits, a_dq, a_pq);
    end
    idle_cycle();
    n_vec++;
    if ({a_wr, a_dwr} !== 2'b00) begin
      n_err++; $display("FAIL single_pulse got %b exp 00", {a_wr, a_dwr});
    end
  endtask

  task automatic test_multi();
    for (int i = 1; i <= 3; i++) begin
      send(i == 1, i == 3, (i == 3) ? 6'd10 : 6'd0, {16{i}}, 16'd11, 16'd12);
      n_vec++;
      if ({a_mr_s, a_wr, a_sop, a_eop, a_dwr} !== {i == 3, 1'b1, i == 1, i == 3, i == 3}) begin
        n_err++; $display("FAIL multi_flit%0d got %b exp %b", i,
                          {a_mr_s, a_wr, a_sop, a_eop, a_dwr},
                          {i == 3, 1'b1, i == 1, i == 3, i == 3});
      end
    end
    n_vec++;
    if ({a_bytes, a_flits, a_pcnt} !== {16'd182, 16'd3, 32'd2}) begin
      n_err++; $display("FAIL multi_desc got %0d/%0d/%0d exp 182/3/2",
                        a_bytes, a_flits, a_pcnt);
    end
  endtask

  task automatic test_byte_swap();
    logic [511:0] d;
    logic [511:0] exp_sw;
    d = '0;
    d[7:0]     = 8'h01;
    d[511:504] = 8'h40;
    d[15:8]    = 8'hA5;
    exp_sw = '0;
    for (int i = 0; i < 64; i++) exp_sw[i*8 +: 8] = d[(63-i)*8 +: 8];
    send(1'b1, 1'b1, 6'd0, d, 16'd1, 16'd2);
    n_vec++;
    if (a_data[511:504] !== 8'h01 || a_data[7:0] !== 8'h40) begin
      n_err++; $display("FAIL swap_ends got %h/%h exp 01/40",
                        a_data[511:504], a_data[7:0]);
    end
    n_vec++;
    if (a_data !== exp_sw) begin
      n_err++; $display("FAIL swap_word got %h exp %h", a_data, exp_sw);
    end
    n_vec++;
    if (n_data !== d) begin
      n_err++; $display("FAIL noswap_word got %h exp %h", n_data, d);
    end
  endtask

  task automatic test_stall();
    send(1'b1, 1'b0, 6'd0, {16{32'h5}}, 16'd21, 16'd22);
    desc_rdy = 1'b0;
    in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1; in_meta_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (a_in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_in_ready c%0d got %b exp 0", c, a_in_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (a_wr !== 1'b0) begin
        n_err++; $display("FAIL stall_wr c%0d got %b exp 0", c, a_wr);
      end
    end
    desc_rdy = 1'b1;
    send(1'b0, 1'b0, 6'd0, {16{32'h6}}, 16'd21, 16'd22);
    send(1'b0, 1'b1, 6'd0, {16{32'h7}}, 16'd21, 16'd22);
    n_vec++;
    if ({a_dwr, a_bytes, a_flits} !== {1'b1, 16'd192, 16'd3}) begin
      n_err++; $display("FAIL stall_desc got %b/%0d/%0d exp 1/192/3",
                        a_dwr, a_bytes, a_flits);
    end
  endtask

  task automatic test_truncate();
    for (int i = 1; i <= 6; i++) begin
      send(i == 1, i == 6, 6'd0, {16{i + 32'h100}}, 16'd31, 16'd32);
      n_vec++;
      if ({t_mr_s, t_wr, t_eop, t_dwr, t_trunc} !==
          {i == 6, i <= 4, i == 4, i == 4, i == 4}) begin
        n_err++; $display("FAIL trunc_flit%0d got %b exp %b", i,
                          {t_mr_s, t_wr, t_eop, t_dwr, t_trunc},
                          {i == 6, i <= 4, i == 4, i == 4, i == 4});
      end
      if (i == 4) begin
        n_vec++;
        if ({t_bytes, t_flits} !== {16'd256, 16'd4}) begin
          n_err++; $display("FAIL trunc_desc got %0d/%0d exp 256/4", t_bytes, t_flits);
        end
      end
    end
    n_vec++;
    if ({a_dwr, a_trunc, a_bytes, a_flits} !== {1'b1, 1'b0, 16'd384, 16'd6}) begin
      n_err++; $display("FAIL untrunc_desc got %b/%b/%0d/%0d exp 1/0/384/6",
                        a_dwr, a_trunc, a_bytes, a_flits);
    end
    n_vec++;
    if (t_tcnt !== 32'd1 || a_tcnt !== 32'd0) begin
      n_err++; $display("FAIL trunc_cnt got %0d/%0d exp 1/0", t_tcnt, a_tcnt);
    end
    send(1'b1, 1'b1, 6'd0, {16{32'h9}}, 16'd41, 16'd42);
    n_vec++;
    if ({t_dwr, t_trunc, t_bytes, t_flits, t_pq} !== {1'b1, 1'b0, 16'd64, 16'd1, 16'd42}) begin
      n_err++; $display("FAIL after_trunc got %b/%b/%0d/%0d/%0d exp 1/0/64/1/42",
                        t_dwr, t_trunc, t_bytes, t_flits, t_pq);
    end
    n_vec++;
    if (t_pcnt !== 32'd6 || a_pcnt !== 32'd6) begin
      n_err++; $display("FAIL pkt_cnt got %0d/%0d exp 6/6", t_pcnt, a_pcnt);
    end
  endtask

  task automatic test_orphan();
    send(1'b0, 1'b0, 6'd0, {16{32'hBAD}}, 16'd1, 16'd1);
    n_vec++;
    if ({a_mr_s, a_wr, a_dwr} !== 3'b000 || a_ecnt !== 32'd1) begin
      n_err++; $display("FAIL orphan got %b/%0d exp 000/1", {a_mr_s, a_wr, a_dwr}, a_ecnt);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b0, 6'd0, {16{32'hA1}}, 16'd51, 16'd52);
    send(1'b0, 1'b0, 6'd0, {16{32'hA2}}, 16'd51, 16'd52);
    rst = 1'b1;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_in_ready got %b exp 0", a_in_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({a_wr, a_sop, a_eop, a_dwr, a_trunc} !== 5'b0 || a_data !== '0 ||
        {a_bytes, a_flits, a_dq, a_pq} !== 64'd0 ||
        {a_pcnt, a_tcnt, a_ecnt} !== 96'd0 || t_tcnt !== 32'd0) begin
      n_err++; $display("FAIL rst_outputs got %b bytes %0d pcnt %0d ecnt %0d exp all 0",
                        {a_wr, a_sop, a_eop, a_dwr, a_trunc}, a_bytes, a_pcnt, a_ecnt);
    end
    rst = 1'b0;
    send(1'b1, 1'b1, 6'd0, {16{32'hC3}}, 16'd5, 16'd9);
    n_vec++;
    if ({a_wr, a_sop, a_dwr, a_bytes, a_flits, a_dq, a_pq, a_pcnt} !==
        {1'b1, 1'b1, 1'b1, 16'd64, 16'd1, 16'd5, 16'd9, 32'd1}) begin
      n_err++; $display("FAIL rst_fresh got %b%b%b/%0d/%0d/%0d/%0d/%0d exp 111/64/1/5/9/1",
                        a_wr, a_sop, a_dwr, a_bytes, a_flits, a_dq, a_pq, a_pcnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_byte_swap();
    test_stall();
    test_truncate();
    test_orphan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
